sha256_1024in_core: RTL and testbench

// - Responder end of the hash-request handshake issued by the HMAC controller.
// - Accepts one pre-padded 1024-bit message (two 512-bit SHA-256 blocks) and returns a 256-bit digest.
// - Iterative engine: one compression round per clock, with an on-the-fly 16-word W schedule.
// - Serves both the inner hash and the outer hash of every HMAC-SHA256 / PBKDF2 iteration.

---
 rtl/sha256_1024in_core.sv | 173 +++++++++++++++++
 tb/tb_sha256_1024in_core.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_1024in_core.sv
// ============================================================================
// Module      : sha256_1024in_core
// Description : Iterative SHA-256 engine hashing one pre-padded 1024-bit
//               (two-block) message per request; SHA256_UNROLL2_EN selects
//               two rounds per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_1024in_core #(
    parameter logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          in_valid,
    input  logic [1023:0] in,
    output logic          in_ready,
    output logic          out_valid,
    output logic [255:0]  out,
    input  logic          out_ready
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RND0 = 3'd1,
        MID  = 3'd2,
        RND1 = 3'd3,
        FIN  = 3'd4,
        DONE = 3'd5
    } state_t;

`ifdef SHA256_UNROLL2_EN
    localparam int CNT_W = 5;
`else
    localparam int CNT_W = 6;
`endif

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sched(input logic [31:0] wm2, input logic [31:0] wm7,
                                          input logic [31:0] wm15, input logic [31:0] wm16);
        return (rotr(wm2, 17) ^ rotr(wm2, 19) ^ (wm2 >> 10)) + wm7
             + (rotr(wm15, 7) ^ rotr(wm15, 18) ^ (wm15 >> 3)) + wm16;
    endfunction

    function automatic logic [255:0] round_f(input logic [255:0] s, input logic [31:0] k,
                                             input logic [31:0] wt);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + wt;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        end
        return r;
    endfunction

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      w [16];
    logic [511:0]     blk1;
    logic [255:0]     st;
    logic [255:0]     hh;
    logic [255:0]     st_rnd;
    logic [255:0]     h_sum;
    logic [31:0]      w_new0;
`ifdef SHA256_UNROLL2_EN
    logic [31:0]      w_new1;
`endif

    // W window: w[0] is the word consumed this edge, w[15] the newest scheduled word.
    always_comb begin
        h_sum  = add8(hh, st);
        w_new0 = sched(w[14], w[9], w[1], w[0]);
`ifdef SHA256_UNROLL2_EN
        w_new1 = sched(w[15], w[10], w[2], w[1]);
        st_rnd = round_f(round_f(st, K[{cnt, 1'b0}], w[0]), K[{cnt, 1'b1}], w[1]);
`else
        st_rnd = round_f(st, K[cnt], w[0]);
`endif
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = RND0;
            end
            RND0:    if (cnt == '1) state_nx = MID;
            MID:     state_nx = RND1;
            RND1:    if (cnt == '1) state_nx = FIN;
            FIN:     state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            out       <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE:       cnt <= '0;
                RND0, RND1: cnt <= cnt + 1'b1;
                FIN: begin
                    out_valid <= 1'b1;
                    out       <= h_sum;
                end
                DONE:       if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    // Datapath needs no reset: every field is reloaded on the accepting edge.
    always_ff @(posedge clk_i) begin
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    for (int i = 0; i < 16; i++) w[i] <= in[1023-32*i -: 32];
                    blk1 <= in[511:0];
                    st   <= IV;
                    hh   <= IV;
                end
            end
            RND0, RND1: begin
                st <= st_rnd;
`ifdef SHA256_UNROLL2_EN
                for (int i = 0; i < 14; i++) w[i] <= w[i+2];
                w[14] <= w_new0;
                w[15] <= w_new1;
`else
                for (int i = 0; i < 15; i++) w[i] <= w[i+1];
                w[15] <= w_new0;
`endif
            end
            MID: begin
                hh <= h_sum;
                st <= h_sum;
                for (int i = 0; i < 16; i++) w[i] <= blk1[511-32*i -: 32];
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_sha256_1024in_core.sv
// ============================================================================
// Module      : tb_sha256_1024in_core
// Description : Scoreboard bench for sha256_1024in_core (NIST 2-block vector,
//               backpressure, busy request, reset mid-run, back-to-back, IV).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sha256_1024in_core;

`ifdef SHA256_UNROLL2_EN
    localparam int LAT = 66;
`else
    localparam int LAT = 130;
`endif

    localparam logic [255:0] IV_STD = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    // Alternate start state (SHA-256("abc") digest) for the IV-override instance.
    localparam logic [255:0] IV_ALT = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

    localparam logic [1023:0] NIST_MSG = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000,
        448'h0, 32'h00000000, 32'h000001c0
    };
    localparam logic [255:0] NIST_DIG = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [1023:0] msg;
    logic          in_ready;
    logic          out_valid;
    logic [255:0]  dig;
    logic          out_ready;

    logic          in_valid2;
    logic [1023:0] msg2;
    logic          in_ready2;
    logic          out_valid2;
    logic [255:0]  dig2;

    int            cyc = 0;
    int            n_chk = 0;
    int            n_fail = 0;
    logic [255:0]  exp_q [$];
    int            acc_q [$];
    logic          ov_prev = 1'b0;

    sha256_1024in_core dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .in_valid (in_valid),
        .in       (msg),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out      (dig),
        .out_ready(out_ready)
    );

    sha256_1024in_core #(.IV(IV_ALT)) dut_iv (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .in_valid (in_valid2),
        .in       (msg2),
        .in_ready (in_ready2),
        .out_valid(out_valid2),
        .out      (dig2),
        .out_ready(1'b1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference SHA-256 compression written from the textbook definition.
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0]  wv [64];
        logic [31:0]  v [8];
        logic [31:0]  t1, t2;
        logic [255:0] r;
        for (int t = 0; t < 16; t++) wv[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            wv[t] = (ror(wv[t-2], 17) ^ ror(wv[t-2], 19) ^ (wv[t-2] >> 10)) + wv[t-7]
                  + (ror(wv[t-15], 7) ^ ror(wv[t-15], 18) ^ (wv[t-15] >> 3)) + wv[t-16];
        for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + wv[t];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
        return r;
    endfunction

    function automatic logic [255:0] hash2(input logic [255:0] iv, input logic [1023:0] m);
        return compress(compress(iv, m[1023:512]), m[511:0]);
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic send(input logic [1023:0] m, input logic [255:0] e);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
        end else begin
            msg      = m;
            in_valid = 1'b1;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            acc_q.push_back(cyc);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!(in_ready && !out_valid && exp_q.size() == 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        if (n >= 400) begin
            n_fail++;
            $display("FAIL idle_timeout: %0d digests outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic wait_ov();
        int n;
        n = 0;
        while (!out_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_rise", {255'd0, out_valid}, 256'd1);
    endtask

    // Monitor: each rising out_valid consumes one scoreboard entry.
    initial begin : monitor
        logic [255:0] e;
        int           a;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && !ov_prev) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL spurious_out_valid: got out=%h, expected no output", dig);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    chk("digest", dig, e);
                    chk("latency", 256'(cyc - a), 256'(LAT));
                end
            end
            ov_prev = out_valid;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL global_timeout: simulation exceeded time limit, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int           a2;
        int           n;
        logic [255:0] e2;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        msg       = '0;
        out_ready = 1'b1;
        in_valid2 = 1'b0;
        msg2      = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", {255'd0, out_valid}, 256'd0);
        chk("rst_out", dig, 256'd0);
        chk("rst_in_ready", {255'd0, in_ready}, 256'd1);
        chk("rst_iv_out_valid", {255'd0, out_valid2}, 256'd0);
        rst_n = 1'b1;

        // Single NIST request, then digest retained while idle.
        send(NIST_MSG, NIST_DIG);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("out_retained", dig, NIST_DIG);

        // Backpressure: hold the digest for 20 cycles.
        out_ready = 1'b0;
        send(NIST_MSG, NIST_DIG);
        @(negedge clk);
        wait_ov();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_out_valid", {255'd0, out_valid}, 256'd1);
            chk("bp_out", dig, NIST_DIG);
            chk("bp_in_ready", {255'd0, in_ready}, 256'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_out_valid", {255'd0, out_valid}, 256'd0);
        chk("bp_release_in_ready", {255'd0, in_ready}, 256'd1);
        wait_idle();

        // Busy request at E10 must be ignored.
        send(NIST_MSG, NIST_DIG);
        repeat (9) @(negedge clk);
        msg      = ~NIST_MSG;
        in_valid = 1'b1;
        chk("busy_in_ready", {255'd0, in_ready}, 256'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_idle();

        // Reset around round 40 of the second block.
        send(NIST_MSG, NIST_DIG);
        repeat (105) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        acc_q.delete();
        chk("midrst_out_valid", {255'd0, out_valid}, 256'd0);
        chk("midrst_out", dig, 256'd0);
        chk("midrst_in_ready", {255'd0, in_ready}, 256'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        chk("postrst_quiet", {255'd0, out_valid}, 256'd0);
        send(NIST_MSG, NIST_DIG);
        wait_idle();

        // Back-to-back: NIST then all-zero input.
        send(NIST_MSG, NIST_DIG);
        send('0, hash2(IV_STD, '0));
        wait_idle();

        // Overridden IV instance.
        e2 = hash2(IV_ALT, NIST_MSG);
        @(negedge clk);
        chk("iv_in_ready", {255'd0, in_ready2}, 256'd1);
        msg2      = NIST_MSG;
        in_valid2 = 1'b1;
        @(posedge clk);
        #1;
        a2        = cyc;
        in_valid2 = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid2 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("iv_digest", dig2, e2);
        chk("iv_latency", 256'(cyc - a2), 256'(LAT));

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
